// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and constants for the configuration write arbiter
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMMIT      = 2'd1,
    WAIT_PERIOD = 2'd2
  } cfg_state_e;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY      = 7'd4;

  localparam int NUM_REGS = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with one-hot grant
// On a tie the requester that was not granted most recently wins.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       en_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  assign grant_o[0] = en_i & valid_i[0] & (~valid_i[1] | last_grant_i);
  assign grant_o[1] = en_i & valid_i[1] & (~valid_i[0] | ~last_grant_i);

endmodule

// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - serialises SPI and host writes into the PWM/output config registers
// Duty-cycle writes can be held until a PWM period boundary so duty never changes mid-period.
module cfg_write_arbiter
  import cfg_pkg::*;
#(
  parameter int         SYNC_DUTY  = 1,
  parameter logic [7:0] RESET_DUTY = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [6:0] s_addr,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       h_valid,
  input  logic [6:0] h_addr,
  input  logic [7:0] h_data,
  output logic       h_ready,
  input  logic       period_end,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [4:0] wr_strobe,
  output logic       addr_err
);

  cfg_state_e                   state_q, state_d;
  logic                         last_grant_q;
  logic [6:0]                   pend_addr_q;
  logic [7:0]                   pend_data_q;
  logic [NUM_REGS-1:0][7:0]     regs_q;
  logic [NUM_REGS-1:0]          wr_strobe_q;
  logic                         addr_err_q;
  logic [1:0]                   grant;
  logic                         arb_en;
  logic                         xfer;
  logic [6:0]                   req_addr;
  logic [7:0]                   req_data;

  // Ready is forced low during reset even though the state already reads IDLE.
  assign arb_en = (state_q == IDLE) && !rst;

  rr_arbiter2 u_arb (
    .valid_i      ({h_valid, s_valid}),
    .en_i         (arb_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign s_ready  = grant[0];
  assign h_ready  = grant[1];
  assign xfer     = |grant;
  assign req_addr = grant[1] ? h_addr : s_addr;
  assign req_data = grant[1] ? h_data : s_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = (req_addr == ADDR_DUTY && SYNC_DUTY != 0) ? WAIT_PERIOD : COMMIT;
        end
      end
      COMMIT:      state_d = IDLE;
      WAIT_PERIOD: if (period_end) state_d = COMMIT;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      regs_q       <= '0;
      regs_q[3'(ADDR_DUTY)] <= RESET_DUTY;
      wr_strobe_q  <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_strobe_q <= '0;
      addr_err_q  <= 1'b0;
      if (state_q == IDLE && xfer) begin
        pend_addr_q  <= req_addr;
        pend_data_q  <= req_data;
        last_grant_q <= grant[1];
      end
      if (state_q == COMMIT) begin
        if (pend_addr_q < 7'(NUM_REGS)) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (pend_addr_q == 7'(i)) begin
              regs_q[i]      <= pend_data_q;
              wr_strobe_q[i] <= 1'b1;
            end
          end
        end else begin
          addr_err_q <= 1'b1;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[3'(ADDR_EN_OUT_LO)];
  assign en_reg_out_15_8 = regs_q[3'(ADDR_EN_OUT_HI)];
  assign en_reg_pwm_7_0  = regs_q[3'(ADDR_EN_PWM_LO)];
  assign en_reg_pwm_15_8 = regs_q[3'(ADDR_EN_PWM_HI)];
  assign pwm_duty_cycle  = regs_q[3'(ADDR_DUTY)];
  assign wr_strobe       = wr_strobe_q;
  assign addr_err        = addr_err_q;

endmodule
